// File: rtl/fpu_vector_sequencer.sv
// Operand sequencer for FPU_Add_Subtract_Function: replays stored operand pairs through the
// beg_FSM/rst_FSM handshake, bounds each wait with a timeout, and records results with flags.
module fpu_vector_sequencer #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int TIMEOUT    = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vec_wr_en,
  input  logic [DEPTH_LOG2-1:0] vec_wr_addr,
  input  logic [W-1:0]          vec_x_in,
  input  logic [W-1:0]          vec_y_in,
  input  logic                  vec_op_in,
  input  logic [DEPTH_LOG2:0]   num_vectors,
  input  logic [1:0]            r_mode,
  input  logic                  start,
  output logic                  beg_FSM,
  output logic                  rst_FSM,
  output logic [W-1:0]          Data_X,
  output logic [W-1:0]          Data_Y,
  output logic                  add_subt,
  output logic [1:0]            fpu_r_mode,
  input  logic                  ready,
  input  logic [W-1:0]          final_result_ieee,
  input  logic                  overflow_flag,
  input  logic                  underflow_flag,
  input  logic [DEPTH_LOG2-1:0] res_rd_addr,
  output logic [W-1:0]          res_rd_data,
  output logic [2:0]            res_rd_flags,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   vec_index,
  output logic [DEPTH_LOG2:0]   timeout_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRIVE, S_LAUNCH, S_WAIT, S_STORE, S_RECOVER, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2*W:0]          vec_mem  [DEPTH];
  logic [W-1:0]          res_mem  [DEPTH];
  logic [2:0]            flag_mem [DEPTH];

  logic [2*W:0]          vec_rd_p0;
  logic [W-1:0]          res_cap_p1;
  logic [2:0]            flags_cap_p1;
  logic [DEPTH_LOG2:0]   num_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  ready_q;
  logic                  rst_hold;
  logic                  ready_rise;
  logic                  wait_expired;
  logic                  last_vec;
  logic [DEPTH_LOG2-1:0] idx;

  assign idx          = vec_index[DEPTH_LOG2-1:0];
  assign ready_rise   = ready & ~ready_q;
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign last_vec     = ((vec_index + (DEPTH_LOG2+1)'(1)) == num_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (num_vectors == '0) ? S_DONE : S_FETCH;
      S_FETCH:        state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = S_LAUNCH;
      S_LAUNCH:       state_nxt = S_WAIT;
      S_WAIT:         if (ready_rise || wait_expired) state_nxt = S_STORE;
      S_STORE:        state_nxt = S_RECOVER;
      S_RECOVER:      state_nxt = last_vec ? S_DONE : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // rst_hold keeps the FPU cleared for the cycle following a sequencer reset
  always_comb begin
    beg_FSM = (state == S_LAUNCH);
    rst_FSM = (state == S_RECOVER) | rst_hold;
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    rst_hold <= rst;
    if (rst) begin
      vec_index   <= '0;
      timeout_cnt <= '0;
      fpu_r_mode  <= '0;
      wait_cnt    <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= ready;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_index   <= '0;
            timeout_cnt <= '0;
            if (num_vectors != '0) fpu_r_mode <= r_mode;
          end
        end
        S_LAUNCH: wait_cnt <= '0;
        S_WAIT: begin
          if (!ready_rise) begin
            if (wait_expired) timeout_cnt <= timeout_cnt + (DEPTH_LOG2+1)'(1);
            else              wait_cnt    <= wait_cnt + CNT_W'(1);
          end
        end
        S_RECOVER: vec_index <= vec_index + (DEPTH_LOG2+1)'(1);
        default: ;
      endcase
    end
  end

  // p0: operand fetch from vector memory
  always_ff @(posedge clk) begin
    if (vec_wr_en && !busy) vec_mem[vec_wr_addr] <= {vec_op_in, vec_x_in, vec_y_in};
    if (state == S_FETCH) vec_rd_p0 <= vec_mem[idx];
    if ((state == S_IDLE || state == S_DONE) && start) num_q <= num_vectors;
  end

  // p1: drive FPU operands, held until the next fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      Data_X   <= '0;
      Data_Y   <= '0;
      add_subt <= 1'b0;
    end else if (state == S_DRIVE) begin
      {add_subt, Data_X, Data_Y} <= vec_rd_p0;
    end
  end

  // p1: capture result on the ready edge, or a zero result tagged as timed out
  always_ff @(posedge clk) begin
    if (state == S_WAIT) begin
      if (ready_rise) begin
        res_cap_p1   <= final_result_ieee;
        flags_cap_p1 <= {1'b0, overflow_flag, underflow_flag};
      end else if (wait_expired) begin
        res_cap_p1   <= '0;
        flags_cap_p1 <= 3'b100;
      end
    end
    if (state == S_STORE) begin
      res_mem[idx]  <= res_cap_p1;
      flag_mem[idx] <= flags_cap_p1;
    end
  end

  // p2: registered result read port, old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      res_rd_data  <= '0;
      res_rd_flags <= '0;
    end else begin
      res_rd_data  <= res_mem[res_rd_addr];
      res_rd_flags <= flag_mem[res_rd_addr];
    end
  end

endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// Bench for fpu_vector_sequencer: a table-driven FPU stub answers each launch, and a
// scoreboard of expected result-memory contents is checked through the read port.
module tb_fpu_vector_sequencer;
  localparam int W   = 32;
  localparam int DL  = 4;
  localparam int TO  = 20;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vec_wr_en = 1'b0;
  logic [DL-1:0] vec_wr_addr = '0;
  logic [W-1:0]  vec_x_in = '0, vec_y_in = '0;
  logic          vec_op_in = 1'b0;
  logic [DL:0]   num_vectors = '0;
  logic [1:0]    r_mode = '0;
  logic          start = 1'b0;
  logic          beg_FSM, rst_FSM, add_subt, busy, done;
  logic [W-1:0]  Data_X, Data_Y, res_rd_data;
  logic [1:0]    fpu_r_mode;
  logic          ready = 1'b0, overflow_flag = 1'b0, underflow_flag = 1'b0;
  logic [W-1:0]  final_result_ieee = '0;
  logic [DL-1:0] res_rd_addr = '0;
  logic [2:0]    res_rd_flags;
  logic [DL:0]   vec_index, timeout_cnt;

  fpu_vector_sequencer #(.W(W), .DEPTH_LOG2(DL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
    .vec_x_in(vec_x_in), .vec_y_in(vec_y_in), .vec_op_in(vec_op_in),
    .num_vectors(num_vectors), .r_mode(r_mode), .start(start),
    .beg_FSM(beg_FSM), .rst_FSM(rst_FSM), .Data_X(Data_X), .Data_Y(Data_Y),
    .add_subt(add_subt), .fpu_r_mode(fpu_r_mode), .ready(ready),
    .final_result_ieee(final_result_ieee), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .res_rd_flags(res_rd_flags), .busy(busy),
    .done(done), .vec_index(vec_index), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct packed {
    logic [DL-1:0] addr;
    logic [31:0]   res;
    logic [2:0]    flags;
  } exp_t;

  vec_t tbl [8];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   beg_cnt = 0;
  int   rstf_cnt = 0;
  logic hang = 1'b0;
  int   lat_cnt = 0;

  function automatic int find_vec(input logic [31:0] x, input logic [31:0] y, input logic op);
    for (int i = 0; i < 8; i++)
      if (tbl[i].x == x && tbl[i].y == y && tbl[i].op == op) return i;
    return -1;
  endfunction

  // FPU stub: ready rises LAT cycles after launch and stays high until rst_FSM
  always @(posedge clk) begin
    int k;
    if (rst_FSM) begin
      ready   <= 1'b0;
      lat_cnt <= 0;
    end else if (beg_FSM && !hang) begin
      lat_cnt <= LAT;
    end else if (lat_cnt == 1) begin
      k = find_vec(Data_X, Data_Y, add_subt);
      ready   <= 1'b1;
      lat_cnt <= 0;
      if (k >= 0) begin
        final_result_ieee <= tbl[k].res;
        overflow_flag     <= tbl[k].flags[1];
        underflow_flag    <= tbl[k].flags[0];
      end else begin
        final_result_ieee <= 32'hDEADBEEF;
        overflow_flag     <= 1'b0;
        underflow_flag    <= 1'b0;
      end
    end else if (lat_cnt > 1) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (beg_FSM === 1'b1) beg_cnt <= beg_cnt + 1;
    if (rst_FSM === 1'b1) rstf_cnt <= rstf_cnt + 1;
  end

  task automatic load(input int addr, input int k);
    vec_wr_en = 1'b1; vec_wr_addr = DL'(addr);
    vec_x_in = tbl[k].x; vec_y_in = tbl[k].y; vec_op_in = tbl[k].op;
    @(posedge clk); #1;
    vec_wr_en = 1'b0;
  endtask

  task automatic expect_res(input int addr, input logic [31:0] res, input logic [2:0] flags);
    exp_t e;
    e.addr = DL'(addr); e.res = res; e.flags = flags;
    sb.push_back(e);
  endtask

  task automatic kick(input int num, input logic [1:0] rm);
    num_vectors = (DL+1)'(num); r_mode = rm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL run_done: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      res_rd_addr = e.addr;
      @(posedge clk); #1;
      checks++;
      if (res_rd_data !== e.res || res_rd_flags !== e.flags) begin
        errors++;
        $display("FAIL result[%0d]: got %h/%b, required %h/%b",
                 e.addr, res_rd_data, res_rd_flags, e.res, e.flags);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({beg_FSM, rst_FSM, busy, done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl: beg,rst_FSM,busy,done=%b required 0100",
               {beg_FSM, rst_FSM, busy, done});
    end
    checks++;
    if (vec_index !== '0 || timeout_cnt !== '0 || fpu_r_mode !== '0 || Data_X !== '0
        || res_rd_flags !== '0 || res_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: idx=%0d tcnt=%0d rm=%b dx=%h rd=%h/%b required all 0",
               vec_index, timeout_cnt, fpu_r_mode, Data_X, res_rd_data, res_rd_flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rst_FSM !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rst_FSM=%b required 0", rst_FSM);
    end
  endtask

  task automatic test_single();
    int cyc, b0;
    load(0, 0);
    expect_res(0, 32'h40400000, 3'b000);
    b0 = beg_cnt;
    kick(1, 2'b10);
    wait_done(cyc);
    checks++;
    if (beg_cnt - b0 !== 1) begin
      errors++;
      $display("FAIL single_beg: pulses=%0d required 1", beg_cnt - b0);
    end
    checks++;
    if (cyc !== 9 || busy !== 1'b0 || fpu_r_mode !== 2'b10) begin
      errors++;
      $display("FAIL single_run: cycles=%0d busy=%b rmode=%b required 9/0/10", cyc, busy, fpu_r_mode);
    end
    check_sb();
  endtask

  task automatic test_mixed();
    int cyc, r0;
    int ks[4] = '{0, 1, 5, 3};
    for (int i = 0; i < 4; i++) begin
      load(i, ks[i]);
      expect_res(i, tbl[ks[i]].res, tbl[ks[i]].flags);
    end
    r0 = rstf_cnt;
    kick(4, 2'b01);
    wait_done(cyc);
    checks++;
    if (rstf_cnt - r0 !== 4 || vec_index !== 5'd4) begin
      errors++;
      $display("FAIL mixed_count: rst_FSM pulses=%0d vec_index=%0d required 4/4",
               rstf_cnt - r0, vec_index);
    end
    check_sb();
  endtask

  task automatic test_timeout();
    int cyc;
    hang = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(i, i + 2);
      expect_res(i, 32'h0, 3'b100);
    end
    kick(3, 2'b00);
    wait_done(cyc);
    checks++;
    if (cyc !== 3 * (TO + 5) || timeout_cnt !== 5'd3) begin
      errors++;
      $display("FAIL timeout_run: cycles=%0d tcnt=%0d required %0d/3", cyc, timeout_cnt, 3 * (TO + 5));
    end
    hang = 1'b0;
    check_sb();
  endtask

  task automatic test_overflow();
    int cyc;
    load(0, 4);
    load(1, 2);
    expect_res(0, 32'h7F800000, 3'b010);
    expect_res(1, 32'h41700000, 3'b000);
    kick(2, 2'b00);
    wait_done(cyc);
    checks++;
    if (timeout_cnt !== '0) begin
      errors++;
      $display("FAIL ovf_tcnt: tcnt=%0d required 0", timeout_cnt);
    end
    check_sb();
  endtask

  task automatic test_rst_mid_run();
    int cyc, n;
    int ks[5] = '{6, 7, 0, 1, 3};
    for (int i = 0; i < 5; i++) load(i, ks[i]);
    kick(5, 2'b11);
    n = 0;
    while (!(vec_index == 5'd2 && beg_FSM === 1'b1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL rst_mid_reach: vector 2 launch not seen, vec_index=%0d", vec_index);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({beg_FSM, rst_FSM, busy, done} !== 4'b0100 || vec_index !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: beg,rst_FSM,busy,done=%b idx=%0d required 0100/0",
               {beg_FSM, rst_FSM, busy, done}, vec_index);
    end
    expect_res(0, tbl[6].res, tbl[6].flags);
    expect_res(1, tbl[7].res, tbl[7].flags);
    check_sb();
    for (int i = 0; i < 5; i++) expect_res(i, tbl[ks[i]].res, tbl[ks[i]].flags);
    kick(5, 2'b11);
    wait_done(cyc);
    checks++;
    if (vec_index !== 5'd5) begin
      errors++;
      $display("FAIL rst_mid_restart: vec_index=%0d required 5", vec_index);
    end
    check_sb();
  endtask

  task automatic test_ignored();
    int cyc, b0;
    b0 = beg_cnt;
    kick(0, 2'b00);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || beg_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL zero_run: done=%b busy=%b beg=%0d required 1/0/0", done, busy, beg_cnt - b0);
    end
    load(0, 0);
    load(1, 1);
    expect_res(0, tbl[0].res, tbl[0].flags);
    expect_res(1, tbl[1].res, tbl[1].flags);
    kick(2, 2'b00);
    load(1, 5);
    kick(1, 2'b00);
    wait_done(cyc);
    checks++;
    if (vec_index !== 5'd2) begin
      errors++;
      $display("FAIL busy_start: vec_index=%0d required 2", vec_index);
    end
    check_sb();
  endtask

  initial begin
    tbl[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    tbl[1] = '{32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 3'b000};
    tbl[2] = '{32'h41200000, 32'h40A00000, 1'b0, 32'h41700000, 3'b000};
    tbl[3] = '{32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000, 3'b000};
    tbl[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    tbl[5] = '{32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 3'b001};
    tbl[6] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
    tbl[7] = '{32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 3'b000};
    #1;
    test_reset();
    test_single();
    test_mixed();
    test_timeout();
    test_overflow();
    test_rst_mid_run();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
